// File: rtl/hc_pkg.sv
`default_nettype none
// ============================================================================
// Module : hc_pkg
// Brief  : Shared types, constants and channel helpers for the hc buffer
//          fabric and the read scheduler.
// Rev    : 1.0  initial release
// ============================================================================
package hc_pkg;

    localparam int HC_BUFFER_SIZE = 4;   // number of addressable buffers
    localparam int BUF_W          = $clog2(HC_BUFFER_SIZE);
    localparam int HC_OFFSET_W    = 8;
    localparam int HC_RD_LEN_W    = 32;  // widest supported job length

    typedef logic [HC_OFFSET_W-1:0] t_request_cmd_offset;

    typedef struct packed {
        logic [BUF_W-1:0]       buffer;
        t_request_cmd_offset    offset;
        logic [HC_RD_LEN_W-1:0] length;
    } t_rd_job;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } t_rd_port_state;

    typedef struct packed {
        logic                valid;
        logic [BUF_W-1:0]    buffer;
        t_request_cmd_offset offset;
    } t_rd_req;

    typedef struct packed {
        logic                valid;
        logic [BUF_W-1:0]    buffer;
        t_request_cmd_offset offset;
        logic [31:0]         data;
    } t_wr_req;

    typedef struct packed {
        logic valid;
        logic clear;
    } t_buf_cmd;

    function automatic t_rd_req read_indexed(input logic [BUF_W-1:0] buffer,
                                             input t_request_cmd_offset offset);
        t_rd_req r;
        r.valid  = 1'b1;
        r.buffer = buffer;
        r.offset = offset;
        return r;
    endfunction

    function automatic t_rd_req read_idle();
        return '0;
    endfunction

    function automatic t_wr_req write_idle();
        return '0;
    endfunction

    function automatic t_buf_cmd buffer_idle();
        return '0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hc_buffers_if.sv
`default_nettype none
// ============================================================================
// Module : hc_buffers_if
// Brief  : Shared buffer channel: indexed reads, writes and per-buffer commands.
// Rev    : 1.0  initial release
// ============================================================================
interface hc_buffers_if;
    import hc_pkg::*;

    t_rd_req                        rd_req;
    logic                           rd_full;
    t_wr_req                        wr_req;
    t_buf_cmd [HC_BUFFER_SIZE-1:0]  buf_cmd;

    modport client (output rd_req, output wr_req, output buf_cmd, input rd_full);
    modport server (input rd_req, input wr_req, input buf_cmd, output rd_full);
endinterface
`default_nettype wire

// File: rtl/hc_rr_pick.sv
`default_nettype none
// ============================================================================
// Module : hc_rr_pick
// Brief  : Combinational round-robin selector; grants the first requester at
//          or after ptr_i, wrapping around.
// Rev    : 1.0  initial release
// ============================================================================
module hc_rr_pick #(
    parameter int N     = 4,
    parameter int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N-1:0]     grant_o,
    output logic             valid_o
);

    logic [PTR_W-1:0] idx;

    always_comb begin
        grant_o = '0;
        valid_o = 1'b0;
        idx     = '0;
        for (int i = 0; i < N; i++) begin
            idx = PTR_W'((int'(ptr_i) + i) % N);
            if (!valid_o && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                valid_o      = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/hc_read_scheduler.sv
`default_nettype none
// ============================================================================
// Module : hc_read_scheduler
// Brief  : Round-robin sharing of the hc_buffers_if read channel between
//          N_REQ job ports. Define HC_RD_SCHED_STATS_EN for issue/stall stats.
// Rev    : 1.0  initial release
// ============================================================================
module hc_read_scheduler
    import hc_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int LEN_W = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [N_REQ-1:0]                  job_valid,
    output logic [N_REQ-1:0]                  job_ready,
    input  logic [N_REQ-1:0][BUF_W-1:0]       job_buffer,
    input  logic [N_REQ-1:0][HC_OFFSET_W-1:0] job_offset,
    input  logic [N_REQ-1:0][LEN_W-1:0]       job_length,
    output logic [N_REQ-1:0]                  job_done,
    output logic                              busy,
    hc_buffers_if.client                      buffers
`ifdef HC_RD_SCHED_STATS_EN
    ,
    output logic [N_REQ-1:0][31:0]            stat_issued,
    output logic [31:0]                       stat_stall
`endif
);

    localparam int          PTR_W    = $clog2(N_REQ);
    localparam logic [31:0] STAT_MAX = '1;

    t_rd_port_state   state_q [N_REQ];
    t_rd_port_state   state_d [N_REQ];
    t_rd_job          job_q   [N_REQ];
    t_rd_job          job_d   [N_REQ];
    logic [N_REQ-1:0] done_q, done_d;
    logic [PTR_W-1:0] rr_q, rr_d;
    logic [N_REQ-1:0] active;
    logic [N_REQ-1:0] grant;
    logic             pick_valid;
    logic             issue;
    logic [PTR_W-1:0] sel;

    always_comb begin
        active = '0;
        for (int p = 0; p < N_REQ; p++) begin
            active[p] = (state_q[p] == ACTIVE);
        end
    end

    hc_rr_pick #(.N(N_REQ)) u_pick (
        .req_i   (active),
        .ptr_i   (rr_q),
        .grant_o (grant),
        .valid_o (pick_valid)
    );

    // Reset suppresses issue so the channel reads idle while reset is held.
    assign issue = pick_valid & ~buffers.rd_full & ~reset;

    always_comb begin
        sel = '0;
        for (int p = 0; p < N_REQ; p++) begin
            if (grant[p]) sel = PTR_W'(p);
        end
    end

    always_comb begin
        state_d = state_q;
        job_d   = job_q;
        done_d  = '0;
        rr_d    = rr_q;
        for (int p = 0; p < N_REQ; p++) begin
            if (state_q[p] == IDLE) begin
                if (job_valid[p]) begin
                    job_d[p].buffer = job_buffer[p];
                    job_d[p].offset = job_offset[p];
                    job_d[p].length = HC_RD_LEN_W'(job_length[p]);
                    // Zero-length jobs complete immediately without a read.
                    if (job_length[p] == '0) done_d[p] = 1'b1;
                    else                     state_d[p] = ACTIVE;
                end
            end else if (issue && grant[p]) begin
                job_d[p].offset = job_q[p].offset + t_request_cmd_offset'(1);
                job_d[p].length = job_q[p].length - HC_RD_LEN_W'(1);
                if (job_q[p].length == HC_RD_LEN_W'(1)) begin
                    state_d[p] = IDLE;
                    done_d[p]  = 1'b1;
                end
            end
        end
        if (issue) begin
            rr_d = (sel == PTR_W'(N_REQ - 1)) ? '0 : sel + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int p = 0; p < N_REQ; p++) begin
                state_q[p] <= IDLE;
                job_q[p]   <= '0;
            end
            done_q <= '0;
            rr_q   <= '0;
        end else begin
            state_q <= state_d;
            job_q   <= job_d;
            done_q  <= done_d;
            rr_q    <= rr_d;
        end
    end

    assign job_ready = ~active;
    assign job_done  = done_q;
    assign busy      = |active;

    assign buffers.rd_req = issue ? read_indexed(job_q[sel].buffer, job_q[sel].offset)
                                  : read_idle();
    assign buffers.wr_req = write_idle();

    for (genvar b = 0; b < HC_BUFFER_SIZE; b++) begin : g_buf_idle
        assign buffers.buf_cmd[b] = buffer_idle();
    end

`ifdef HC_RD_SCHED_STATS_EN
    logic [N_REQ-1:0][31:0] issued_q;
    logic [31:0]            stall_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            issued_q <= '0;
            stall_q  <= '0;
        end else begin
            for (int p = 0; p < N_REQ; p++) begin
                if (issue && grant[p] && issued_q[p] != STAT_MAX) begin
                    issued_q[p] <= issued_q[p] + 32'd1;
                end
            end
            if (pick_valid && buffers.rd_full && stall_q != STAT_MAX) begin
                stall_q <= stall_q + 32'd1;
            end
        end
    end

    assign stat_issued = issued_q;
    assign stat_stall  = stall_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hc_read_scheduler.sv
`default_nettype none
// ============================================================================
// Module : tb_hc_read_scheduler
// Brief  : Directed self-checking bench for hc_read_scheduler.
// Rev    : 1.0  initial release
// ============================================================================
module tb_hc_read_scheduler;
    import hc_pkg::*;

    localparam int N  = 4;
    localparam int LW = 16;
    localparam int RW = 1 + BUF_W + HC_OFFSET_W;

    logic                              clk = 1'b0;
    logic                              reset;
    logic [N-1:0]                      job_valid;
    logic [N-1:0]                      job_ready;
    logic [N-1:0][BUF_W-1:0]           job_buffer;
    logic [N-1:0][HC_OFFSET_W-1:0]     job_offset;
    logic [N-1:0][LW-1:0]              job_length;
    logic [N-1:0]                      job_done;
    logic                              busy;
`ifdef HC_RD_SCHED_STATS_EN
    logic [N-1:0][31:0]                stat_issued;
    logic [31:0]                       stat_stall;
`endif

    hc_buffers_if bufs ();

    hc_read_scheduler #(.N_REQ(N), .LEN_W(LW)) dut (
        .clk        (clk),
        .reset      (reset),
        .job_valid  (job_valid),
        .job_ready  (job_ready),
        .job_buffer (job_buffer),
        .job_offset (job_offset),
        .job_length (job_length),
        .job_done   (job_done),
        .busy       (busy),
        .buffers    (bufs)
`ifdef HC_RD_SCHED_STATS_EN
        ,
        .stat_issued(stat_issued),
        .stat_stall (stat_stall)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [RW-1:0] rdw(input int b, input int o);
        return {1'b1, BUF_W'(b), HC_OFFSET_W'(o)};
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        job_valid    = '0;
        bufs.rd_full = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic post(input int p, input int b, input int o, input int l);
        job_buffer[p] = BUF_W'(b);
        job_offset[p] = HC_OFFSET_W'(o);
        job_length[p] = LW'(l);
        job_valid[p]  = 1'b1;
    endtask

    initial begin
        job_buffer = '0;
        job_offset = '0;
        job_length = '0;
        @(negedge clk);

        // Reset state
        do_reset();
        #1;
        check("rst_ready", job_ready, 4'hF);
        check("rst_done",  job_done,  4'h0);
        check("rst_busy",  busy,      1'b0);
        check("rst_rd",    bufs.rd_req,  '0);
        check("rst_wr",    bufs.wr_req,  '0);
        check("rst_buf",   bufs.buf_cmd, '0);

        // Single job, port 0, five consecutive reads
        post(0, 1, 'h10, 5);
        #1 check("s1_ready_pre", job_ready[0], 1'b1);
        step();
        job_valid = '0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("s1_rd_%0d", i), bufs.rd_req, rdw(1, 'h10 + i));
            if (i == 0) begin
                check("s1_busy", busy, 1'b1);
                check("s1_ready_act", job_ready[0], 1'b0);
            end
            step();
        end
        #1;
        check("s1_rd_end", bufs.rd_req, '0);
        check("s1_done",   job_done, 4'h1);
        check("s1_busy_end", busy, 1'b0);
        check("s1_ready_end", job_ready, 4'hF);
        step();
        #1 check("s1_done_clr", job_done, 4'h0);

        // Three ports, length 3 each, round-robin interleave
        do_reset();
        post(0, 0, 'h40, 3);
        post(1, 1, 'h50, 3);
        post(2, 2, 'h60, 3);
        #1 step();
        job_valid = '0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (i < 9) check($sformatf("s2_rd_%0d", i), bufs.rd_req,
                             rdw(i % 3, 'h40 + 16 * (i % 3) + i / 3));
            else       check("s2_rd_end", bufs.rd_req, '0);
            check($sformatf("s2_done_%0d", i), job_done,
                  (i >= 7) ? (64'd1 << (i - 7)) : 64'd0);
            step();
        end

        // Backpressure: port 1, length 4, read_full in cycles 2..4
        do_reset();
        post(1, 2, 'h80, 4);
        #1 step();
        job_valid = '0;
        for (int c = 1; c <= 8; c++) begin
            bufs.rd_full = (c >= 2 && c <= 4);
            #1;
            if (c == 1)               check("s3_rd_1", bufs.rd_req, rdw(2, 'h80));
            else if (c >= 5 && c <= 7) check($sformatf("s3_rd_%0d", c), bufs.rd_req, rdw(2, 'h80 + c - 4));
            else                       check($sformatf("s3_rd_%0d", c), bufs.rd_req, '0);
            check($sformatf("s3_done_%0d", c), job_done, (c == 8) ? 4'h2 : 4'h0);
            step();
        end
        bufs.rd_full = 1'b0;
`ifdef HC_RD_SCHED_STATS_EN
        check("s3_stat_stall",  stat_stall,     32'd3);
        check("s3_stat_issued", stat_issued[1], 32'd4);
`endif

        // Offset wrap on port 2, plus a job accepted on port 0 mid-stream
        do_reset();
        post(2, 3, 'hFE, 3);
        #1 step();
        job_valid = '0;
        post(0, 0, 'h55, 1);
        #1 check("s4_rd_1", bufs.rd_req, rdw(3, 'hFE));
        step();
        job_valid = '0;
        #1 check("s4_rd_2", bufs.rd_req, rdw(0, 'h55));
        step();
        #1;
        check("s4_rd_3",   bufs.rd_req, rdw(3, 'hFF));
        check("s4_done_3", job_done, 4'h1);
        step();
        #1;
        check("s4_rd_4",   bufs.rd_req, rdw(3, 'h00));
        check("s4_done_4", job_done, 4'h0);
        step();
        #1;
        check("s4_rd_5",   bufs.rd_req, '0);
        check("s4_done_5", job_done, 4'h4);
        step();

        // Zero-length job on port 3
        post(3, 0, 'h00, 0);
        #1 step();
        job_valid = '0;
        #1;
        check("s5_rd",    bufs.rd_req, '0);
        check("s5_done",  job_done, 4'h8);
        check("s5_ready", job_ready, 4'hF);
        check("s5_busy",  busy, 1'b0);
        step();
        #1 check("s5_done_clr", job_done, 4'h0);

        // Reset mid-job, then a fresh job
        do_reset();
        post(0, 1, 'h00, 10);
        #1 step();
        job_valid = '0;
        for (int i = 0; i < 4; i++) begin
            #1 check($sformatf("s6_rd_%0d", i), bufs.rd_req, rdw(1, i));
            step();
        end
        reset = 1'b1;
        #1 check("s6_rd_in_rst", bufs.rd_req, '0);
        step();
        reset = 1'b0;
        #1;
        check("s6_rd_after",   bufs.rd_req, '0);
        check("s6_ready_after", job_ready, 4'hF);
        check("s6_done_after", job_done, 4'h0);
        check("s6_busy_after", busy, 1'b0);
`ifdef HC_RD_SCHED_STATS_EN
        check("s6_stat_issued", stat_issued[0], 32'd0);
`endif
        step();
        #1 check("s6_no_done", job_done, 4'h0);
        post(0, 1, 'h30, 2);
        #1 step();
        job_valid = '0;
        #1 check("s6_new_rd_0", bufs.rd_req, rdw(1, 'h30));
        step();
        #1 check("s6_new_rd_1", bufs.rd_req, rdw(1, 'h31));
        step();
        #1;
        check("s6_new_done", job_done, 4'h1);
        check("s6_new_rd_end", bufs.rd_req, '0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
